// File: rtl/clock_pkg.sv
// Shared definitions for the century clock stages (sec/min/hour).
package clock_pkg;
   localparam int HOUR_W = 5;
   localparam int BCD_W  = 4;
   localparam logic [HOUR_W-1:0] NOON = 5'd12;

   // Display format selector, shared with any stage that renders hours.
   typedef enum logic {
      MODE_24H = 1'b0,
      MODE_12H = 1'b1
   } hour_mode_e;
endpackage

// File: rtl/rise_detect.sv
// Single-cycle rising-edge detector on a level input, clocked by the tick clock.
module rise_detect (
   input  logic clk_1Hz,
   input  logic rst_n,
   input  logic level,
   output logic pulse
);
   logic prev;

   // Remember last cycle's level; cleared on reset so a level already high
   // at release is seen as a fresh edge.
   always_ff @(posedge clk_1Hz or negedge rst_n) begin
      if (!rst_n) prev <= 1'b0;
      else        prev <= level;
   end

   assign pulse = level & ~prev;
endmodule

// File: rtl/counter_hour.sv
// Hour stage: counts minute-stage carries, manual set, 12/24h BCD display.
module counter_hour
   import clock_pkg::*;
#(
   // Terminal count; must fit in HOUR_W bits (<= 31).
   parameter int HOUR_MAX = 23
) (
   input  logic              clk_1Hz,
   input  logic              rst_n,
   input  logic              inc_hour,
   input  logic              set_en,
   input  logic              set_up,
   input  logic              set_dn,
   input  logic              mode_12h,
   output logic [HOUR_W-1:0] out_hour,
   output logic              inc_day,
   output logic              pm,
   output logic [BCD_W-1:0]  disp_tens,
   output logic [BCD_W-1:0]  disp_ones
);
   localparam logic [HOUR_W-1:0] MAX = HOUR_W'(HOUR_MAX);

   logic tick, up, dn;

   rise_detect u_tick (.clk_1Hz(clk_1Hz), .rst_n(rst_n), .level(inc_hour), .pulse(tick));
   rise_detect u_up   (.clk_1Hz(clk_1Hz), .rst_n(rst_n), .level(set_up),   .pulse(up));
   rise_detect u_dn   (.clk_1Hz(clk_1Hz), .rst_n(rst_n), .level(set_dn),   .pulse(dn));

   // Binary hour -> displayed hour (12h folds 0/12 to 12, 13..23 to 1..11)
   // -> packed {tens, ones} BCD.
   function automatic logic [2*BCD_W-1:0] to_bcd(input logic [HOUR_W-1:0] h,
                                                 input hour_mode_e m);
      logic [HOUR_W-1:0] d;
      d = h;
      if (m == MODE_12H) begin
         if (h == 5'd0 || h == NOON) d = NOON;
         else if (h > NOON)          d = h - NOON;
      end
      return {BCD_W'(d / 5'd10), BCD_W'(d % 5'd10)};
   endfunction

   // Count on carry edges in run mode; step with buttons in set mode.
   // Carry edges during set mode are consumed by the detector and dropped.
   always_ff @(posedge clk_1Hz or negedge rst_n) begin
      if (!rst_n) begin
         out_hour <= '0;
         inc_day  <= 1'b0;
      end else if (set_en) begin
         if (up && !dn) begin
            out_hour <= (out_hour == MAX) ? '0 : out_hour + 5'd1;
            inc_day  <= 1'b0;
         end else if (dn && !up) begin
            out_hour <= (out_hour == '0) ? MAX : out_hour - 5'd1;
            inc_day  <= 1'b0;
         end
      end else if (tick) begin
         if (out_hour == MAX) begin
            out_hour <= '0;
            inc_day  <= 1'b1;
         end else begin
            out_hour <= out_hour + 5'd1;
            inc_day  <= 1'b0;
         end
      end
   end

   // Display path is purely combinational off the registered hour.
   always_comb begin
      {disp_tens, disp_ones} = to_bcd(out_hour, hour_mode_e'(mode_12h));
      pm = (out_hour >= NOON);
   end
endmodule

// File: doc/counter_hour.md
# counter_hour

Hour stage of the century clock, directly downstream of the minute counter. Counts hours 0..HOUR_MAX on each rising edge of the minute stage's `inc_hour` level, supports manual hour setting, and produces binary, 12/24-hour display and BCD outputs. It also produces an `inc_day` level for the day/date stage, following the same carry convention the minute stage uses.

## Interface
- `HOUR_MAX`, 23: terminal count; the counter wraps to 0 after this value.
- `clk_1Hz` in 1: system tick clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inc_hour` in 1: carry level from the minute stage. Rises when minutes wrap and is held for at least one minute.
- `set_en` in 1: level. 1 = set mode (counting frozen, buttons active).
- `set_up` in 1: debounced button level; a rising edge increments the hour in set mode.
- `set_dn` in 1: debounced button level; a rising edge decrements the hour in set mode.
- `mode_12h` in 1: 0 = 24-hour display, 1 = 12-hour display.
- `out_hour` out 5: binary hour, 0..HOUR_MAX.
- `inc_day` out 1: carry level to the day stage.
- `pm` out 1: 1 when `out_hour` ≥ 12.
- `disp_tens` out 4: BCD tens digit of the displayed hour.
- `disp_ones` out 4: BCD ones digit of the displayed hour.

## Operation
- **Edge detection.**
  - Registers `inc_prev`, `up_prev`, `dn_prev` capture last cycle's `inc_hour`, `set_up` and `set_dn`.
  - Event pulses: `tick = inc_hour & ~inc_prev`, and likewise for `up` and `dn`.
- **Run mode** (`set_en` = 0):
  - On `tick`, if `out_hour` == HOUR_MAX: `out_hour` ← 0, `inc_day` ← 1.
  - On `tick` otherwise: `out_hour` += 1, `inc_day` ← 0.
  - No tick: hold all outputs.
- **Set mode** (`set_en` = 1):
  - `tick` is ignored. It is still registered into `inc_prev`, so it is not replayed on exit.
  - `up` increments `out_hour`, wrapping HOUR_MAX→0.
  - `dn` decrements `out_hour`, wrapping 0→HOUR_MAX.
  - `inc_day` is forced to 0 on any set action and never asserted by a set wrap.
  - `up` and `dn` in the same cycle: no change.
- **Display.** Combinational from registered `out_hour` and `mode_12h`.
  - 24-hour mode: displayed value d = `out_hour`.
  - 12-hour mode: d = 12 when `out_hour` is 0 or 12; d = `out_hour`−12 when `out_hour` > 12; otherwise d = `out_hour`.
  - `disp_tens` = d/10, `disp_ones` = d%10, each a 4-bit BCD digit (tens 0..2).
- **Width rule.** `out_hour` arithmetic is 5-bit; HOUR_MAX must be ≤ 31. Values never exceed HOUR_MAX.
- **Reset.**
  - Asynchronous, any time, including mid-set.
  - `out_hour` = 0, `inc_day` = 0, all `*_prev` = 0.
  - Resulting display: `pm` = 0; `disp_tens`/`disp_ones` = 0/0 in 24-hour mode, 1/2 in 12-hour mode.
  - If `inc_hour` is already high at reset release, it counts as a rising edge on the first clock. This is intentional and matches the minute stage carry.

## Timing
- The hour updates on the first `clk_1Hz` rising edge at which `inc_hour` = 1 and `inc_prev` = 0. That is one cycle after `inc_hour` rises, when `inc_hour` changes between clock edges.
- `inc_day` changes in the same cycle as the `out_hour` update and holds until the next counted tick or set action.
- Set buttons: one step per rising edge. A button held high produces no repeat.
- Display outputs follow `out_hour` with zero cycles of added latency.
- Toggling `set_en` takes effect on the same clock edge; it never causes a count by itself.

## Structure
- Package `clock_pkg`: `HOUR_W` = 5, `BCD_W` = 4, `NOON` = 12, and a mode enum for 12/24-hour display. The min/sec stages share the same package.
- Sub-module `rise_detect` (clk_1Hz, rst_n, in, out pulse), instantiated three times.
- Binary→display→BCD conversion stays as a combinational function in this module.

## Test plan
- Reset, then 24 `inc_hour` rising edges spaced 60 clocks apart.
  - `out_hour` steps 1..23, then 0.
  - `inc_day` = 1 only after the 23→0 step and cleared at the next step.
- `inc_hour` held high for 60 clocks → exactly one increment.
- Set mode from `out_hour` = 0: one `set_dn` edge → 23 with `inc_day` = 0. Then two `set_up` edges → 1.
- `set_en` = 1 while `inc_hour` rises, then `set_en` released with `inc_hour` still high → hour unchanged.
- `mode_12h` = 1 at `out_hour` = 0, 12, 13, 23:
  - tens/ones = 1/2, 1/2, 0/1, 1/1.
  - `pm` = 0, 1, 1, 1.
- Assert `rst_n` low mid-set at `out_hour` = 17 → all outputs reset immediately, without waiting for a clock edge.
